// File: rtl/spw_ctrl_pio.sv
// ============================================================================
//  Module   : spw_ctrl_pio
//  Purpose  : Avalon-MM control/status port for the SpaceWire CODEC.
//             Control register with DATA/SET/CLR aliases and self-clearing
//             pulse bits, plus a synchronised status bank with rising-edge
//             capture and a maskable level interrupt.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spw_ctrl_pio #(
  parameter int                   OUT_WIDTH  = 3,
  parameter logic [OUT_WIDTH-1:0] OUT_RESET  = '0,
  parameter logic [OUT_WIDTH-1:0] PULSE_MASK = '0,
  parameter int                   PULSE_LEN  = 4,
  parameter int                   IN_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic [OUT_WIDTH-1:0] out_port,
  input  logic [IN_WIDTH-1:0]  in_port,
  output logic                 irq
);

  // Register word addresses
  localparam logic [2:0] C_ADDR_DATA   = 3'd0;
  localparam logic [2:0] C_ADDR_SET    = 3'd1;
  localparam logic [2:0] C_ADDR_CLR    = 3'd2;
  localparam logic [2:0] C_ADDR_STATUS = 3'd3;
  localparam logic [2:0] C_ADDR_EDGE   = 3'd4;
  localparam logic [2:0] C_ADDR_MASK   = 3'd5;

  localparam logic [7:0] C_PCNT_LOAD   = 8'(PULSE_LEN);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [OUT_WIDTH-1:0] ctrl_q,   ctrl_d;
  logic [7:0]           pcnt_q,   pcnt_d;
  logic [IN_WIDTH-1:0]  sync1_q;
  logic [IN_WIDTH-1:0]  sync2_q;
  logic [IN_WIDTH-1:0]  sync_d_q;
  logic [IN_WIDTH-1:0]  edge_q,   edge_d;
  logic [IN_WIDTH-1:0]  mask_q,   mask_d;
  logic                 irq_q,    irq_d;

  // --------------------------------------------------------------------------
  // Bus write decode
  // --------------------------------------------------------------------------
  logic                 w_wr_en;
  logic                 w_wr_data;
  logic                 w_wr_set;
  logic                 w_wr_clr;
  logic                 w_wr_edge;
  logic                 w_wr_mask;
  logic [OUT_WIDTH-1:0] w_wd_out;
  logic [IN_WIDTH-1:0]  w_wd_in;

  assign w_wr_en   = chipselect & ~write_n;
  assign w_wr_data = w_wr_en & (address == C_ADDR_DATA);
  assign w_wr_set  = w_wr_en & (address == C_ADDR_SET);
  assign w_wr_clr  = w_wr_en & (address == C_ADDR_CLR);
  assign w_wr_edge = w_wr_en & (address == C_ADDR_EDGE);
  assign w_wr_mask = w_wr_en & (address == C_ADDR_MASK);
  assign w_wd_out  = writedata[OUT_WIDTH-1:0];
  assign w_wd_in   = writedata[IN_WIDTH-1:0];

  // Upper writedata bits beyond both register widths are intentionally dropped
  logic w_unused_wd;
  assign w_unused_wd = ^writedata;

  // --------------------------------------------------------------------------
  // Control register and pulse counter
  // --------------------------------------------------------------------------
  logic                 w_expire;
  logic [OUT_WIDTH-1:0] w_ctrl_base;
  logic                 w_pload;

  // pcnt leaving 1 is the single cycle on which pulse bits are dropped
  assign w_expire    = (pcnt_q == 8'd1);
  assign w_ctrl_base = w_expire ? (ctrl_q & ~PULSE_MASK) : ctrl_q;

  // Next control value: the bus write is applied on top of any expiry so
  // bits the write sets always survive a coincident expiry
  always_comb begin
    ctrl_d = w_ctrl_base;
    if (w_wr_data) begin
      ctrl_d = w_wd_out;
    end else if (w_wr_set) begin
      ctrl_d = w_ctrl_base | w_wd_out;
    end else if (w_wr_clr) begin
      ctrl_d = w_ctrl_base & ~w_wd_out;
    end
  end

  // Reload on a DATA/SET write that writes a pulse bit as 1 or raises one;
  // a reload while running extends the pulse rather than stacking it
  assign w_pload = (w_wr_data | w_wr_set) &
                   (|(PULSE_MASK & ((ctrl_d & ~ctrl_q) | w_wd_out)));

  // Counter next state: reload wins, otherwise count down to zero and hold
  always_comb begin
    pcnt_d = pcnt_q;
    if (w_pload) begin
      pcnt_d = C_PCNT_LOAD;
    end else if (pcnt_q != 8'd0) begin
      pcnt_d = pcnt_q - 8'd1;
    end
  end

  // Control register; reset does not arm the counter even for pulse bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= OUT_RESET;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  // Shared pulse down-counter; reset aborts any pulse in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q <= 8'd0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Status input path
  // --------------------------------------------------------------------------
  logic [IN_WIDTH-1:0] w_rise;

  // Two-flop synchroniser followed by a delay stage for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      sync_d_q <= '0;
    end else begin
      sync1_q  <= in_port;
      sync2_q  <= sync1_q;
      sync_d_q <= sync2_q;
    end
  end

  assign w_rise = sync2_q & ~sync_d_q;

  // Edge capture: write-1-to-clear, a same-cycle rising edge takes priority
  always_comb begin
    edge_d = edge_q;
    if (w_wr_edge) begin
      edge_d = edge_q & ~w_wd_in;
    end
    edge_d = edge_d | w_rise;
  end

  // Interrupt mask register update
  always_comb begin
    mask_d = mask_q;
    if (w_wr_mask) begin
      mask_d = w_wd_in;
    end
  end

  // Level interrupt computed from the current capture and mask state
  assign irq_d = |(edge_q & mask_q);

  // Edge capture, mask and registered interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_q <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      edge_q <= edge_d;
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read mux: combinational, zero-extended, no side effects
  // --------------------------------------------------------------------------
  // Select the addressed register and place it at the bottom of the word
  always_comb begin
    readdata = 32'd0;
    case (address)
      C_ADDR_DATA:   readdata[OUT_WIDTH-1:0] = ctrl_q;
      C_ADDR_STATUS: readdata[IN_WIDTH-1:0]  = sync2_q;
      C_ADDR_EDGE:   readdata[IN_WIDTH-1:0]  = edge_q;
      C_ADDR_MASK:   readdata[IN_WIDTH-1:0]  = mask_q;
      default:       readdata = 32'd0;
    endcase
  end

  assign out_port = ctrl_q;
  assign irq      = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_spw_ctrl_pio.sv
// ============================================================================
//  Module   : tb_spw_ctrl_pio
//  Purpose  : Directed self-checking bench for spw_ctrl_pio
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spw_ctrl_pio;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [2:0]  out_port;
  logic [7:0]  in_port;
  logic        irq;

  int total = 0;
  int bad   = 0;

  spw_ctrl_pio #(
    .OUT_WIDTH  (3),
    .OUT_RESET  (3'b101),
    .PULSE_MASK (3'b100),
    .PULSE_LEN  (4),
    .IN_WIDTH   (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .in_port    (in_port),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Write lands on the next rising edge; returns 1ns after that edge
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] rd;

  initial begin
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    in_port    = 8'h00;

    // ---------------- reset state ----------------
    tick(2);
    check("rst_out", {29'd0, out_port}, 32'h5);
    check("rst_irq", {31'd0, irq}, 32'h0);
    bus_read(3'd4, rd);
    check("rst_edge", rd, 32'h0);
    reset_n = 1'b1;
    tick(1);

    // ---------------- set / clear aliases ----------------
    bus_write(3'd0, 32'h2);
    check("data_wr", {29'd0, out_port}, 32'h2);
    bus_write(3'd1, 32'h1);
    check("set_wr", {29'd0, out_port}, 32'h3);
    bus_write(3'd2, 32'h2);
    check("clr_wr", {29'd0, out_port}, 32'h1);
    bus_read(3'd1, rd);
    check("set_rd0", rd, 32'h0);
    bus_read(3'd2, rd);
    check("clr_rd0", rd, 32'h0);
    bus_read(3'd0, rd);
    check("data_rd", rd, 32'h1);

    // ---------------- single pulse: high exactly 4 cycles ----------------
    bus_write(3'd1, 32'h4);
    check("pulse_t0", {29'd0, out_port}, 32'h5);
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      check($sformatf("pulse_t%0d", i), {29'd0, out_port}, (i < 4) ? 32'h5 : 32'h1);
    end

    // ---------------- extended pulse: re-set at T+2, clears at T+6 ----------------
    bus_write(3'd1, 32'h4);
    check("ext_t0", {29'd0, out_port}, 32'h5);
    tick(1);
    check("ext_t1", {29'd0, out_port}, 32'h5);
    bus_write(3'd1, 32'h4);
    check("ext_t2", {29'd0, out_port}, 32'h5);
    for (int j = 3; j <= 6; j++) begin
      tick(1);
      check($sformatf("ext_t%0d", j), {29'd0, out_port}, (j < 6) ? 32'h5 : 32'h1);
    end

    // ---------------- early clear of a pulse bit ----------------
    bus_write(3'd1, 32'h4);
    tick(1);
    bus_write(3'd2, 32'h4);
    check("early_clr", {29'd0, out_port}, 32'h1);
    tick(4);
    check("early_exp", {29'd0, out_port}, 32'h1);

    // ---------------- edge capture and irq latency ----------------
    bus_write(3'd5, 32'h1);
    bus_read(3'd5, rd);
    check("mask_rd", rd, 32'h1);
    in_port = 8'h01;
    tick(1);
    bus_read(3'd3, rd);
    check("stat_e1", rd, 32'h0);
    tick(1);
    bus_read(3'd3, rd);
    check("stat_e2", rd, 32'h1);
    bus_read(3'd4, rd);
    check("edge_e2", rd, 32'h0);
    tick(1);
    bus_read(3'd4, rd);
    check("edge_e3", rd, 32'h1);
    check("irq_e3", {31'd0, irq}, 32'h0);
    tick(1);
    check("irq_e4", {31'd0, irq}, 32'h1);
    bus_write(3'd4, 32'h1);
    bus_read(3'd4, rd);
    check("edge_w1c", rd, 32'h0);
    check("irq_c0", {31'd0, irq}, 32'h1);
    tick(1);
    check("irq_c1", {31'd0, irq}, 32'h0);

    // ---------------- simultaneous edge and W1C: edge wins ----------------
    in_port = 8'h00;
    tick(4);
    in_port = 8'h01;
    tick(2);
    bus_write(3'd4, 32'h1);
    bus_read(3'd4, rd);
    check("sim_edge", rd, 32'h1);
    tick(1);
    check("sim_irq", {31'd0, irq}, 32'h1);
    bus_write(3'd4, 32'h1);
    bus_read(3'd4, rd);
    check("sim_clr", rd, 32'h0);

    // ---------------- masking ----------------
    bus_write(3'd5, 32'h0);
    in_port = 8'h81;
    tick(4);
    bus_read(3'd4, rd);
    check("msk_edge", rd, 32'h80);
    check("msk_irq0", {31'd0, irq}, 32'h0);
    bus_read(3'd3, rd);
    check("msk_stat", rd, 32'h81);
    bus_write(3'd5, 32'hFFFF_FF80);
    bus_read(3'd5, rd);
    check("msk_rd", rd, 32'h80);
    check("msk_irq_m0", {31'd0, irq}, 32'h0);
    tick(1);
    check("msk_irq_m1", {31'd0, irq}, 32'h1);

    // ---------------- width handling and unused addresses ----------------
    bus_write(3'd0, 32'hFFFF_FFF8);
    check("wide_out", {29'd0, out_port}, 32'h0);
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_read(3'd6, rd);
    check("addr6", rd, 32'h0);
    bus_read(3'd7, rd);
    check("addr7", rd, 32'h0);
    check("addr6_nowr", {29'd0, out_port}, 32'h0);

    // ---------------- reset mid-pulse: counter not armed ----------------
    bus_write(3'd1, 32'h4);
    check("mp_set", {29'd0, out_port}, 32'h4);
    reset_n = 1'b0;
    #1;
    check("mp_rst_out", {29'd0, out_port}, 32'h5);
    check("mp_rst_irq", {31'd0, irq}, 32'h0);
    bus_read(3'd4, rd);
    check("mp_rst_edge", rd, 32'h0);
    bus_read(3'd5, rd);
    check("mp_rst_mask", rd, 32'h0);
    #2;
    reset_n = 1'b1;
    tick(6);
    check("mp_hold", {29'd0, out_port}, 32'h5);
    check("mp_irq", {31'd0, irq}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
